dm_arbiter: RTL and testbench

- Shares the single data memory (DRAM) between NCORES processor cores and the host communication port.
- Replaces the per-core selector when the design scales to multiple cores.
- A registered mode FSM follows `status` and routes the DRAM either to the com port (load/readback) or to a round-robin arbiter over core requests.
- Aggregates per-core `end_process` flags into one system-level done signal.

---
 rtl/dm_arbiter.sv | 157 +++++++++++++++
 tb/tb_dm_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: routes the DRAM to the host com port (load/readback) or round-robins it
// over core requests in RUN, and aggregates per-core end flags. Optional macro: DM_ARB_PERF_EN.
module dm_arbiter #(
    parameter int NCORES = 4,
    parameter int AW     = 16,
    parameter int DW     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           status,
    input  logic [DW-1:0]        com_data_in,
    input  logic [AW-1:0]        com_addr,
    input  logic                 com_wr_en,
    output logic [DW-1:0]        com_data_out,
    input  logic [NCORES-1:0]    core_req,
    input  logic [NCORES-1:0]    core_wr_en,
    input  logic [NCORES*AW-1:0] core_addr,
    input  logic [NCORES*DW-1:0] core_data,
    input  logic [NCORES-1:0]    core_end,
    output logic [NCORES-1:0]    core_gnt,
    output logic [NCORES-1:0]    core_rvalid,
    output logic [DW-1:0]        core_rdata,
    output logic [AW-1:0]        DM_addr,
    output logic [DW-1:0]        DM_data_in,
    output logic                 DM_write_en,
    input  logic [DW-1:0]        DM_out,
`ifdef DM_ARB_PERF_EN
    output logic [31:0]          stall_cnt,
`endif
    output logic                 end_process
);

    localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_LOAD     = 2'b01,
        S_RUN      = 2'b10,
        S_READBACK = 2'b11
    } mode_t;

    mode_t             r_mode;
    logic [PW-1:0]     r_rr_ptr;
    logic [NCORES-1:0] r_done_mask;
    logic [NCORES-1:0] r_rvalid;
    logic [DW-1:0]     r_rdata_hold;
    logic              r_end;

    logic              w_found;
    logic [PW-1:0]     w_sel;
    logic [PW-1:0]     w_ptr_nxt;
    logic [NCORES-1:0] w_gnt;
    logic [NCORES-1:0] w_done_nxt;
    logic              w_enter_run;

    assign w_enter_run = (r_mode != S_RUN) && (status == 2'b10);

    // Round-robin search starting at r_rr_ptr; cores already done never win.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_sel   = '0;
        if (r_mode == S_RUN) begin
            for (int k = 0; k < NCORES; k++) begin
                idx = (int'(r_rr_ptr) + k) % NCORES;
                if (!w_found && core_req[idx] && !r_done_mask[idx]) begin
                    w_found = 1'b1;
                    w_sel   = PW'(idx);
                end
            end
        end
        w_gnt = '0;
        if (w_found) w_gnt[w_sel] = 1'b1;
        w_ptr_nxt = (int'(w_sel) == NCORES - 1) ? '0 : w_sel + 1'b1;
    end

    always_comb begin
        DM_addr      = '0;
        DM_data_in   = '0;
        DM_write_en  = 1'b0;
        com_data_out = '0;
        case (r_mode)
            S_LOAD: begin
                DM_addr      = com_addr;
                DM_data_in   = com_data_in;
                DM_write_en  = com_wr_en;
                com_data_out = DM_out;
            end
            S_READBACK: begin
                DM_addr      = com_addr;
                DM_data_in   = com_data_in;
                com_data_out = DM_out;
            end
            S_RUN: begin
                if (w_found) begin
                    DM_addr     = core_addr[int'(w_sel)*AW +: AW];
                    DM_data_in  = core_data[int'(w_sel)*DW +: DW];
                    DM_write_en = core_wr_en[w_sel];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_done_nxt = r_done_mask;
        if (w_enter_run)          w_done_nxt = '0;
        else if (r_mode == S_RUN) w_done_nxt = r_done_mask | core_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode       <= S_IDLE;
            r_rr_ptr     <= '0;
            r_done_mask  <= '0;
            r_rvalid     <= '0;
            r_rdata_hold <= '0;
            r_end        <= 1'b0;
        end else begin
            r_mode      <= mode_t'(status);
            r_done_mask <= w_done_nxt;
            r_end       <= &w_done_nxt;
            if (w_found) r_rr_ptr <= w_ptr_nxt;
            // DM_out carries the granted read data in the cycle after the grant.
            r_rvalid <= (w_found && !core_wr_en[w_sel]) ? w_gnt : '0;
            if (|r_rvalid) r_rdata_hold <= DM_out;
        end
    end

    assign core_gnt    = w_gnt;
    assign core_rvalid = r_rvalid;
    assign core_rdata  = (|r_rvalid) ? DM_out : r_rdata_hold;
    assign end_process = r_end;

`ifdef DM_ARB_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] w_stall_n;
    logic [32:0] w_stall_sum;

    always_comb begin
        w_stall_n = '0;
        for (int k = 0; k < NCORES; k++)
            if (core_req[k] && !r_done_mask[k] && !w_gnt[k]) w_stall_n = w_stall_n + 32'd1;
        w_stall_sum = {1'b0, r_stall_cnt} + {1'b0, w_stall_n};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               r_stall_cnt <= '0;
        else if (w_enter_run)     r_stall_cnt <= '0;
        else if (r_mode == S_RUN) r_stall_cnt <= w_stall_sum[32] ? 32'hFFFF_FFFF : w_stall_sum[31:0];
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small synchronous DRAM model (1-cycle read latency).
module tb_dm_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  status;
    logic [15:0] com_data_in;
    logic [15:0] com_addr;
    logic        com_wr_en;
    logic [15:0] com_data_out;
    logic [3:0]  core_req;
    logic [3:0]  core_wr_en;
    logic [63:0] core_addr;
    logic [63:0] core_data;
    logic [3:0]  core_end;
    logic [3:0]  core_gnt;
    logic [3:0]  core_rvalid;
    logic [15:0] core_rdata;
    logic [15:0] DM_addr;
    logic [15:0] DM_data_in;
    logic        DM_write_en;
    logic [15:0] DM_out;
    logic        end_process;
`ifdef DM_ARB_PERF_EN
    logic [31:0] stall_cnt;
`endif

    logic [15:0] mem [0:255];
    int n_vec = 0;
    int n_bad = 0;

    dm_arbiter #(.NCORES(4), .AW(16), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .status(status),
        .com_data_in(com_data_in), .com_addr(com_addr), .com_wr_en(com_wr_en),
        .com_data_out(com_data_out),
        .core_req(core_req), .core_wr_en(core_wr_en), .core_addr(core_addr),
        .core_data(core_data), .core_end(core_end),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .DM_addr(DM_addr), .DM_data_in(DM_data_in), .DM_write_en(DM_write_en),
        .DM_out(DM_out),
`ifdef DM_ARB_PERF_EN
        .stall_cnt(stall_cnt),
`endif
        .end_process(end_process)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (DM_write_en) mem[DM_addr[7:0]] <= DM_data_in;
        DM_out <= mem[DM_addr[7:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0; status = 2'b00;
        com_data_in = '0; com_addr = '0; com_wr_en = 1'b0;
        core_req = '0; core_wr_en = '0; core_addr = '0; core_data = '0; core_end = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h30] = 16'h1234;
        DM_out = 16'h0000;
        tick(); tick();
        chk("rst_gnt", core_gnt, 4'b0000);
        chk("rst_rvalid", core_rvalid, 4'b0000);
        chk("rst_rdata", core_rdata, 16'h0000);
        chk("rst_we", DM_write_en, 1'b0);
        chk("rst_addr", DM_addr, 16'h0000);
        chk("rst_end", end_process, 1'b0);
        chk("rst_com_out", com_data_out, 16'h0000);

        // load 0x0010 = A5A5 through the com port
        rst_n = 1'b1; status = 2'b01;
        tick();
        com_addr = 16'h0010; com_data_in = 16'hA5A5; com_wr_en = 1'b1; #1;
        chk("load_we", DM_write_en, 1'b1);
        chk("load_addr", DM_addr, 16'h0010);
        chk("load_data", DM_data_in, 16'hA5A5);
        chk("load_gnt", core_gnt, 4'b0000);
        tick();
        com_wr_en = 1'b0; status = 2'b11;
        tick();
        com_wr_en = 1'b1; com_data_in = 16'hFFFF; #1;
        chk("rb_data", com_data_out, 16'hA5A5);
        chk("rb_we_forced0", DM_write_en, 1'b0);
        tick();
        chk("rb_no_write", com_data_out, 16'hA5A5);
        com_wr_en = 1'b0;

        // round-robin over four constant writers
        status = 2'b10;
        tick();
        core_req = 4'b1111; core_wr_en = 4'b1111;
        core_addr = {16'h0043, 16'h0042, 16'h0041, 16'h0040};
        core_data = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        #1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rr_gnt%0d", k), core_gnt, 4'b0001 << (k % 4));
            chk($sformatf("rr_addr%0d", k), DM_addr, 16'h0040 + 16'(k % 4));
            tick();
        end

        // single read by core 2 of preloaded 0x0030
        core_req = 4'b0100; core_wr_en = 4'b0000;
        core_addr = {16'h0000, 16'h0030, 16'h0000, 16'h0000};
        #1;
        chk("rd_gnt", core_gnt, 4'b0100);
        chk("rd_rvalid_t", core_rvalid, 4'b0000);
        chk("rd_addr", DM_addr, 16'h0030);
        chk("rd_we", DM_write_en, 1'b0);
        tick();
        core_req = 4'b0000; #1;
        chk("rd_rvalid_t1", core_rvalid, 4'b0100);
        chk("rd_data_t1", core_rdata, 16'h1234);
        tick();
        chk("rd_rvalid_t2", core_rvalid, 4'b0000);
        chk("rd_data_hold", core_rdata, 16'h1234);

        // core 3 write moves the pointer back to 0
        core_req = 4'b1000; core_wr_en = 4'b1000;
        core_addr = {16'h0050, 16'h0000, 16'h0000, 16'h0000};
        #1;
        chk("ptr_gnt3", core_gnt, 4'b1000);
        tick();

        // core 1 writes BEEF to 0x0020 while core 3 reads it
        core_req = 4'b1010; core_wr_en = 4'b0010;
        core_addr = {16'h0020, 16'h0000, 16'h0020, 16'h0000};
        core_data = {16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
        #1;
        chk("mix_gnt1", core_gnt, 4'b0010);
        chk("mix_we1", DM_write_en, 1'b1);
        chk("mix_addr1", DM_addr, 16'h0020);
        chk("mix_data1", DM_data_in, 16'hBEEF);
        tick();
        core_req = 4'b1000; #1;
        chk("mix_gnt3", core_gnt, 4'b1000);
        chk("mix_we3", DM_write_en, 1'b0);
        chk("mix_addr3", DM_addr, 16'h0020);
        tick();
        core_req = 4'b0000; #1;
        chk("mix_rvalid", core_rvalid, 4'b1000);
        chk("mix_rdata", core_rdata, 16'hBEEF);
        chk("run_com_out0", com_data_out, 16'h0000);

        // status goes to readback in the same cycle a read is granted
        core_req = 4'b0001; core_wr_en = 4'b0000;
        core_addr = {16'h0000, 16'h0000, 16'h0000, 16'h0030};
        status = 2'b11; #1;
        chk("ms_gnt", core_gnt, 4'b0001);
        tick();
        com_addr = 16'h0010; #1;
        chk("ms_rvalid", core_rvalid, 4'b0001);
        chk("ms_rdata", core_rdata, 16'h1234);
        chk("ms_gnt_off", core_gnt, 4'b0000);
        chk("ms_com_addr", DM_addr, 16'h0010);
        tick();
        chk("ms_com_out", com_data_out, 16'hA5A5);
        chk("ms_gnt_off2", core_gnt, 4'b0000);
        chk("ms_rvalid_off", core_rvalid, 4'b0000);
        chk("ms_rdata_hold", core_rdata, 16'h1234);

        // end_process aggregation, pointer is at core 1
        status = 2'b10; core_req = 4'b0000;
        tick();
        core_end = 4'b0001; #1;
        chk("done_end0", end_process, 1'b0);
        tick();
        core_end = 4'b0010;
        tick();
        core_end = 4'b0100; core_req = 4'b0111; core_wr_en = 4'b0111;
        core_addr = {16'h0043, 16'h0042, 16'h0041, 16'h0040};
        #1;
        chk("done_skip_gnt", core_gnt, 4'b0100);
        tick();
        core_end = 4'b1000; #1;
        chk("done_all_excl", core_gnt, 4'b0000);
        chk("done_we0", DM_write_en, 1'b0);
        chk("done_end_pre", end_process, 1'b0);
        tick();
        core_end = 4'b0000; core_req = 4'b0000; #1;
        chk("done_end_set", end_process, 1'b1);
        status = 2'b00;
        tick();
        core_req = 4'b1111; #1;
        chk("idle_gnt", core_gnt, 4'b0000);
        chk("idle_addr", DM_addr, 16'h0000);
        chk("idle_end_sticky", end_process, 1'b1);
        status = 2'b10;
        tick();
        chk("rerun_end_clr", end_process, 1'b0);
        chk("rerun_gnt", core_gnt, 4'b1000);

        // asynchronous reset while core 3's read is being granted
        rst_n = 1'b0; #1;
        chk("arst_gnt", core_gnt, 4'b0000);
        chk("arst_end", end_process, 1'b0);
        tick();
        chk("arst_rvalid", core_rvalid, 4'b0000);
        chk("arst_rdata", core_rdata, 16'h0000);
        core_req = 4'b0000; rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
